// File: rtl/dff_pipe_bank.sv
// -----------------------------------------------------------------------------
// dff_pipe_bank
//   Bank of CHANNELS independent WIDTH-bit delay lines, each DEPTH stages deep.
//   Every stage carries a valid bit. Each lane can stall on its own. A global
//   flush clears every lane. Each lane also reports how many of its stages
//   hold valid data. This is the generic retiming / skew-balancing register
//   block placed between datapath stages. With CHANNELS=1 and DEPTH=1 it
//   behaves like a plain D flip-flop.
//
// Parameters
//   WIDTH      data bits per lane (1..64)
//   CHANNELS   number of independent lanes (1..16)
//   DEPTH      stages per lane (1..32) = latency in active edges
//   RESET_VAL  value loaded into every data stage on reset/flush
//              (zero-extended or truncated to WIDTH bits)
//   NEGEDGE    1: state updates on the falling edge of clk, 0: on the rising edge
//
// Ports
//   clk      clock; the active edge is selected by NEGEDGE
//   reset    synchronous, active-high; sampled on the active edge
//   en       per-lane advance enable; 0 makes the lane hold all of its stages
//   d_valid  per-lane input valid, captured together with d when en[c]=1
//   d        lane c input data at [c*WIDTH +: WIDTH]
//   flush    synchronous clear of all lanes, same effect as reset
//   q        lane c last-stage data at [c*WIDTH +: WIDTH]
//   q_valid  per-lane last-stage valid
//   count    lane c valid-stage count at [c*CW +: CW], CW = $clog2(DEPTH+1)
// -----------------------------------------------------------------------------
module dff_pipe_bank #(
  parameter int          WIDTH     = 8,
  parameter int          CHANNELS  = 1,
  parameter int          DEPTH     = 1,
  parameter logic [63:0] RESET_VAL = 64'h34,
  parameter bit          NEGEDGE   = 1'b1,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          en,
  input  logic [CHANNELS-1:0]          d_valid,
  input  logic [CHANNELS*WIDTH-1:0]    d,
  input  logic                         flush,
  output logic [CHANNELS*WIDTH-1:0]    q,
  output logic [CHANNELS-1:0]          q_valid,
  output logic [CHANNELS*CW-1:0]       count
);

  localparam logic [WIDTH-1:0] RST_DATA = RESET_VAL[WIDTH-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      // Stage 0 is the input end, stage DEPTH-1 drives q.
      logic [DEPTH-1:0][WIDTH-1:0] data_reg, data_next;
      logic [DEPTH-1:0]            valid_reg, valid_next;
      logic [CW-1:0]               count_reg, count_next;

      // Next state for flush and advance. Reset is applied in the register
      // process itself and takes priority over everything computed here.
      always_comb begin
        data_next  = data_reg;
        valid_next = valid_reg;
        count_next = count_reg;
        if (flush) begin
          data_next  = {DEPTH{RST_DATA}};
          valid_next = '0;
          count_next = '0;
        end else if (en[gi]) begin
          // The data stage loads d even when d_valid is low. Invalid words
          // still move through the lane; only the valid bit marks them.
          data_next[0]  = d[gi*WIDTH +: WIDTH];
          valid_next[0] = d_valid[gi];
          for (int k = 1; k < DEPTH; k++) begin
            data_next[k]  = data_reg[k-1];
            valid_next[k] = valid_reg[k-1];
          end
          // Count changes only when exactly one valid word enters or leaves.
          // It therefore stays equal to the popcount of valid_reg.
          if (d_valid[gi] && !valid_reg[DEPTH-1]) begin
            count_next = count_reg + CW'(1);
          end else if (!d_valid[gi] && valid_reg[DEPTH-1]) begin
            count_next = count_reg - CW'(1);
          end
        end
      end

      if (NEGEDGE) begin : g_neg
        always_ff @(negedge clk) begin
          if (reset) begin
            data_reg  <= {DEPTH{RST_DATA}};
            valid_reg <= '0;
            count_reg <= '0;
          end else begin
            data_reg  <= data_next;
            valid_reg <= valid_next;
            count_reg <= count_next;
          end
        end
      end else begin : g_pos
        always_ff @(posedge clk) begin
          if (reset) begin
            data_reg  <= {DEPTH{RST_DATA}};
            valid_reg <= '0;
            count_reg <= '0;
          end else begin
            data_reg  <= data_next;
            valid_reg <= valid_next;
            count_reg <= count_next;
          end
        end
      end

      // Outputs come straight from registers, with no path from the inputs.
      assign q[gi*WIDTH +: WIDTH] = data_reg[DEPTH-1];
      assign q_valid[gi]          = valid_reg[DEPTH-1];
      assign count[gi*CW +: CW]   = count_reg;

`ifndef SYNTHESIS
      always_comb begin
        assert (reset || count_reg == CW'($countones(valid_reg)))
          else $error("dff_pipe_bank lane %0d: count out of step with valid bits", gi);
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_dff_pipe_bank.sv
// Scoreboard bench for dff_pipe_bank.
//   dut_a: W=8, C=2, D=3, falling-edge active. Inputs are driven just after
//          the rising edge and checked on the next rising edge.
//   dut_b: W=8, C=1, D=1, rising-edge active (primitive-flop form). Inputs
//          are driven just after the falling edge and checked on the next
//          falling edge.
// The reference model keeps each lane as a fixed-length queue of
// {valid,data} words. The expected count is the number of valid words in
// that queue.
module tb_dff_pipe_bank;
  localparam int W = 8, C = 2, D = 3, CWA = 2;
  localparam logic [7:0] RV = 8'h34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a signals
  logic             reset = 1'b0, flush = 1'b0;
  logic [C-1:0]     en = '0, dv = '0;
  logic [C*W-1:0]   d = '0;
  logic [C*W-1:0]   q;
  logic [C-1:0]     qv;
  logic [C*CWA-1:0] cnt;

  // dut_b signals
  logic       reset2 = 1'b0, flush2 = 1'b0;
  logic [0:0] en2 = '0, dv2 = '0, qv2, cnt2;
  logic [7:0] d2 = '0, q2;

  dff_pipe_bank #(.WIDTH(W), .CHANNELS(C), .DEPTH(D), .RESET_VAL(64'h34), .NEGEDGE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .d_valid(dv), .d(d), .flush(flush),
    .q(q), .q_valid(qv), .count(cnt));

  dff_pipe_bank #(.WIDTH(8), .CHANNELS(1), .DEPTH(1), .RESET_VAL(64'h34), .NEGEDGE(1'b0)) dut_b (
    .clk(clk), .reset(reset2), .en(en2), .d_valid(dv2), .d(d2), .flush(flush2),
    .q(q2), .q_valid(qv2), .count(cnt2));

  int n_checks = 0, n_fail = 0;

  task automatic check(string name, int step, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard for dut_a ----------------
  typedef struct { bit v; bit [7:0] d; } ent_t;
  typedef struct { int step; logic [15:0] q; logic [1:0] qv; logic [3:0] cnt; } exp_t;
  ent_t lane_m[C][$];
  exp_t exp_a[$];
  int   step_a = 0;

  task automatic model_a(bit rst, bit fl, bit [1:0] e, bit [1:0] v, bit [15:0] dd);
    exp_t x;
    ent_t w;
    x.step = step_a;
    for (int c = 0; c < C; c++) begin
      int n = 0;
      if (rst || fl) begin
        lane_m[c].delete();
        w.v = 1'b0; w.d = RV;
        repeat (D) lane_m[c].push_back(w);
      end else if (e[c]) begin
        w.v = v[c]; w.d = dd[c*8 +: 8];
        lane_m[c].push_front(w);
        void'(lane_m[c].pop_back());
      end
      foreach (lane_m[c][k]) if (lane_m[c][k].v) n++;
      x.q[c*8 +: 8]    = lane_m[c][D-1].d;
      x.qv[c]          = lane_m[c][D-1].v;
      x.cnt[c*2 +: 2]  = 2'(n);
    end
    exp_a.push_back(x);
  endtask

  task automatic step(bit rst, bit fl, bit [1:0] e, bit [1:0] v, bit [15:0] dd);
    @(posedge clk); #1;
    reset = rst; flush = fl; en = e; dv = v; d = dd;
    step_a++;
    model_a(rst, fl, e, v, dd);
  endtask

  // Monitor for dut_a: one expected entry per falling edge, compared on the
  // following rising edge. The rising edge itself must leave q unchanged.
  initial begin
    exp_t x;
    logic [15:0] snap;
    forever begin
      @(posedge clk);
      if (exp_a.size() != 0) begin
        x = exp_a.pop_front();
        check("a_q",     x.step, 32'(q),   32'(x.q));
        check("a_qv",    x.step, 32'(qv),  32'(x.qv));
        check("a_count", x.step, 32'(cnt), 32'(x.cnt));
        $display("a step %0d: q=%h qv=%b count=%h", x.step, q, qv, cnt);
        snap = q;
        #2;
        check("a_no_rise_change", x.step, 32'(q), 32'(snap));
      end
    end
  end

  // ---------------- model + scoreboard for dut_b ----------------
  typedef struct { int step; logic [7:0] q; logic qv; logic cnt; } exp2_t;
  exp2_t exp_b[$];
  int    step_b = 0;
  bit [7:0] m2_q = RV;
  bit       m2_v = 1'b0;

  task automatic step2(bit rst, bit fl, bit e, bit v, bit [7:0] dd);
    exp2_t x;
    @(negedge clk); #1;
    reset2 = rst; flush2 = fl; en2 = e; dv2 = v; d2 = dd;
    step_b++;
    if (rst || fl) begin m2_q = RV; m2_v = 1'b0; end
    else if (e)    begin m2_q = dd; m2_v = v;    end
    x.step = step_b; x.q = m2_q; x.qv = m2_v; x.cnt = m2_v;
    exp_b.push_back(x);
  endtask

  initial begin
    exp2_t x;
    logic [7:0] snap;
    forever begin
      @(negedge clk);
      if (exp_b.size() != 0) begin
        x = exp_b.pop_front();
        check("b_q",     x.step, 32'(q2),   32'(x.q));
        check("b_qv",    x.step, 32'(qv2),  32'(x.qv));
        check("b_count", x.step, 32'(cnt2), 32'(x.cnt));
        $display("b step %0d: q=%h qv=%b count=%b", x.step, q2, qv2, cnt2);
        snap = q2;
        #2;
        check("b_no_fall_change", x.step, 32'(q2), 32'(snap));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    fork
      begin : drive_a
        // reset
        step(1, 0, 2'b11, 2'b11, 16'hFFFF);
        step(1, 0, 2'b00, 2'b00, 16'h0000);
        // latency: lane0 01..06, lane1 81..86
        for (int i = 1; i <= 6; i++) step(0, 0, 2'b11, 2'b11, {8'(8'h80 + i), 8'(i)});
        // stall: refill with A1,A2, then hold lane0 for 4 edges while lane1 runs
        step(1, 0, 2'b00, 2'b00, 16'h0);
        step(0, 0, 2'b11, 2'b11, 16'hB1A1);
        step(0, 0, 2'b11, 2'b11, 16'hB2A2);
        for (int i = 0; i < 4; i++)
          step(0, 0, 2'b10, 2'($urandom_range(0, 3)), 16'($urandom));
        for (int i = 0; i < 4; i++) step(0, 0, 2'b11, 2'b00, 16'h0000);
        // bubbles: valid 1,0,1 with data 11,22,33, then drain
        step(0, 0, 2'b11, 2'b11, 16'h1111);
        step(0, 0, 2'b11, 2'b00, 16'h2222);
        step(0, 0, 2'b11, 2'b11, 16'h3333);
        for (int i = 0; i < 3; i++) step(0, 0, 2'b11, 2'b00, 16'h4444);
        // flush with a full pipeline, then reset+flush together
        for (int i = 0; i < 3; i++) step(0, 0, 2'b11, 2'b11, 16'h5A5A);
        step(0, 1, 2'b11, 2'b11, 16'h6B6B);
        for (int i = 0; i < 3; i++) step(0, 0, 2'b11, 2'b11, 16'h7C7C);
        step(1, 1, 2'b11, 2'b11, 16'h8D8D);
        // random traffic
        for (int i = 0; i < 300; i++)
          step($urandom_range(0, 79) == 0, $urandom_range(0, 39) == 0,
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom));
        @(posedge clk); #1;
        en = '0; reset = 1'b0; flush = 1'b0;
      end
      begin : drive_b
        step2(1, 0, 1, 1, 8'hEE);
        step2(0, 0, 1, 1, 8'h01);
        step2(0, 0, 1, 0, 8'h02);
        step2(0, 0, 0, 1, 8'h03);
        step2(0, 1, 1, 1, 8'h04);
        for (int i = 0; i < 100; i++)
          step2($urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        @(negedge clk); #1;
        en2 = '0; reset2 = 1'b0; flush2 = 1'b0;
      end
    join
    // Both scoreboards must drain within a bounded number of cycles.
    for (int i = 0; i < 10 && (exp_a.size() != 0 || exp_b.size() != 0); i++) @(posedge clk);
    #3;
    check("scoreboard_drained", 0, 32'(exp_a.size() + exp_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
